// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: valid/ready handshake with a 2-entry skid buffer
// (main register M drives the outputs, skid register S absorbs back-pressure).
// Synchronous flush; optional suppression of writes to register 0.
// Optional macro MEM_WB_PIPE_PERF_EN adds saturating retire/stall counters.
module mem_wb_pipe #(
    parameter int unsigned INST_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [DATA_W-1:0] in_res,
    input  logic              in_wr_en,
    input  logic [ADDR_W-1:0] in_write_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [DATA_W-1:0] out_res,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_write_addr
`ifdef MEM_WB_PIPE_PERF_EN
    ,
    output logic [31:0]       retire_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned CNT_W = 32;

    logic              m_v_q, m_v_d, s_v_q, s_v_d;
    logic [INST_W-1:0] m_inst_q, m_inst_d, s_inst_q, s_inst_d;
    logic [DATA_W-1:0] m_res_q, m_res_d, s_res_q, s_res_d;
    logic              m_wr_q, m_wr_d, s_wr_q, s_wr_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d, s_addr_q, s_addr_d;

    logic accept;
    logic drain;
    logic m_free;

    // Handshake terms; in_ready depends only on held state
    always_comb begin
        in_ready  = ~s_v_q;
        out_valid = m_v_q;
        accept    = in_valid & ~s_v_q;
        drain     = m_v_q & out_ready;
        m_free    = ~m_v_q | drain;
        out_inst       = m_inst_q;
        out_res        = m_res_q;
        out_write_addr = m_addr_q;
        out_wr_en      = m_v_q & m_wr_q & ~(ZERO_REG & (m_addr_q == ADDR_W'(0)));
    end

    // Next-state for main/skid registers; flush overrides accept and drain
    always_comb begin
        m_v_d    = m_v_q;
        m_inst_d = m_inst_q;
        m_res_d  = m_res_q;
        m_wr_d   = m_wr_q;
        m_addr_d = m_addr_q;
        s_v_d    = s_v_q;
        s_inst_d = s_inst_q;
        s_res_d  = s_res_q;
        s_wr_d   = s_wr_q;
        s_addr_d = s_addr_q;
        if (flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (m_free) begin
            if (s_v_q) begin
                m_v_d    = 1'b1;
                m_inst_d = s_inst_q;
                m_res_d  = s_res_q;
                m_wr_d   = s_wr_q;
                m_addr_d = s_addr_q;
                s_v_d    = 1'b0;
            end else if (accept) begin
                m_v_d    = 1'b1;
                m_inst_d = in_inst;
                m_res_d  = in_res;
                m_wr_d   = in_wr_en;
                m_addr_d = in_write_addr;
            end else begin
                m_v_d = 1'b0;
            end
        end else if (accept) begin
            s_v_d    = 1'b1;
            s_inst_d = in_inst;
            s_res_d  = in_res;
            s_wr_d   = in_wr_en;
            s_addr_d = in_write_addr;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_v_q    <= 1'b0;
            m_inst_q <= '0;
            m_res_q  <= '0;
            m_wr_q   <= 1'b0;
            m_addr_q <= '0;
            s_v_q    <= 1'b0;
            s_inst_q <= '0;
            s_res_q  <= '0;
            s_wr_q   <= 1'b0;
            s_addr_q <= '0;
        end else begin
            m_v_q    <= m_v_d;
            m_inst_q <= m_inst_d;
            m_res_q  <= m_res_d;
            m_wr_q   <= m_wr_d;
            m_addr_q <= m_addr_d;
            s_v_q    <= s_v_d;
            s_inst_q <= s_inst_d;
            s_res_q  <= s_res_d;
            s_wr_q   <= s_wr_d;
            s_addr_q <= s_addr_d;
        end
    end

`ifdef MEM_WB_PIPE_PERF_EN
    logic [CNT_W-1:0] retire_q, retire_d, stall_q, stall_d;

    // Saturating counters; flush does not touch them
    always_comb begin
        retire_d = retire_q;
        stall_d  = stall_q;
        if (drain && out_wr_en && (retire_q != {CNT_W{1'b1}})) begin
            retire_d = retire_q + CNT_W'(1);
        end
        if (m_v_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            retire_q <= retire_d;
            stall_q  <= stall_d;
        end
    end

    assign retire_cnt = retire_q;
    assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe: directed scenarios plus randomized traffic
// checked against a 2-deep FIFO reference model.
module tb_mem_wb_pipe;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] res;
        logic        wr;
        logic [2:0]  addr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_inst = '0;
    logic [15:0] in_res = '0;
    logic        in_wr_en = 1'b0;
    logic [2:0]  in_write_addr = '0;

    logic        in_ready, out_valid, out_wr_en;
    logic [15:0] out_inst, out_res;
    logic [2:0]  out_write_addr;
    logic        z_in_ready, z_out_valid, z_out_wr_en;
    logic [15:0] z_out_inst, z_out_res;
    logic [2:0]  z_out_write_addr;
`ifdef MEM_WB_PIPE_PERF_EN
    logic [31:0] retire_cnt, stall_cnt, z_retire_cnt, z_stall_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    ent_t mq[$];
    int unsigned exp_retire = 0;
    int unsigned exp_stall = 0;

    always #5 clk = ~clk;

    mem_wb_pipe #(.INST_W(16), .DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_res(in_res), .in_wr_en(in_wr_en), .in_write_addr(in_write_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_res(out_res), .out_wr_en(out_wr_en), .out_write_addr(out_write_addr)
`ifdef MEM_WB_PIPE_PERF_EN
        , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
    );

    mem_wb_pipe #(.INST_W(16), .DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(z_in_ready), .in_inst(in_inst),
        .in_res(in_res), .in_wr_en(in_wr_en), .in_write_addr(in_write_addr),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_inst(z_out_inst),
        .out_res(z_out_res), .out_wr_en(z_out_wr_en), .out_write_addr(z_out_write_addr)
`ifdef MEM_WB_PIPE_PERF_EN
        , .retire_cnt(z_retire_cnt), .stall_cnt(z_stall_cnt)
`endif
    );

    // Advance one clock and update the FIFO reference model (capacity 2)
    task automatic cycle();
        bit   acc, drn, fl;
        ent_t e;
        acc = in_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && out_ready;
        fl  = flush;
        e   = '{in_inst, in_res, in_wr_en, in_write_addr};
        if (drn && mq[0].wr && (mq[0].addr != 3'd0)) exp_retire++;
        if ((mq.size() > 0) && !out_ready) exp_stall++;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic wr, input logic [2:0] addr);
        in_valid      = v;
        in_inst       = 16'hC000 | res;
        in_res        = res;
        in_wr_en      = wr;
        in_write_addr = addr;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 16'h0055, 1'b1, 3'd2);
        repeat (3) cycle();
        mq.delete();
        exp_retire = 0;
        exp_stall = 0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++;
        if (out_wr_en !== 1'b0) $display("FAIL reset_out_wr_en got=%b exp=0", out_wr_en); else pass_cnt++;
        total_cnt++;
        if ({out_inst, out_res, out_write_addr} !== 35'd0)
            $display("FAIL reset_data got=%h/%h/%h exp=0", out_inst, out_res, out_write_addr); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        rst = 1'b1;
        in_valid = 1'b1; in_inst = 16'h1234; in_res = 16'h00AA; in_wr_en = 1'b1; in_write_addr = 3'd3;
        cycle();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_res, out_write_addr, out_wr_en, out_inst} !== {1'b1, 16'h00AA, 3'd3, 1'b1, 16'h1234})
            $display("FAIL first_entry got v=%b res=%h addr=%0d wr=%b inst=%h exp v=1 res=00aa addr=3 wr=1 inst=1234",
                     out_valid, out_res, out_write_addr, out_wr_en, out_inst);
        else pass_cnt++;
        cycle();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), 1'b1, 3'(i));
            cycle();
            total_cnt++;
            if (out_valid !== 1'b1 || out_res !== 16'(i) || in_ready !== 1'b1)
                $display("FAIL stream_%0d got v=%b res=%0d rdy=%b exp v=1 res=%0d rdy=1", i, out_valid, out_res, in_ready, i);
            else pass_cnt++;
        end
        drive(1'b0, 16'd0, 1'b0, 3'd0);
        cycle();
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 16'd5, 1'b1, 3'd1);
        cycle();
        drive(1'b1, 16'd6, 1'b1, 3'd2);
        cycle();
        drive(1'b0, 16'd0, 1'b0, 3'd0);
        total_cnt++;
        if (in_ready !== 1'b0 || out_res !== 16'd5)
            $display("FAIL bp_full got rdy=%b res=%0d exp rdy=0 res=5", in_ready, out_res); else pass_cnt++;
        cycle();
        total_cnt++;
        if (in_ready !== 1'b0 || out_res !== 16'd5 || out_valid !== 1'b1)
            $display("FAIL bp_hold got rdy=%b v=%b res=%0d exp rdy=0 v=1 res=5", in_ready, out_valid, out_res); else pass_cnt++;
        out_ready = 1'b1;
        cycle();
        total_cnt++;
        if (in_ready !== 1'b1 || out_res !== 16'd6 || out_valid !== 1'b1)
            $display("FAIL bp_release got rdy=%b v=%b res=%0d exp rdy=1 v=1 res=6", in_ready, out_valid, out_res); else pass_cnt++;
        cycle();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_empty got v=%b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 16'd7, 1'b1, 3'd1);
        cycle();
        drive(1'b1, 16'd8, 1'b1, 3'd1);
        cycle();
        drive(1'b1, 16'd9, 1'b1, 3'd1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 16'd0, 1'b0, 3'd0);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); else pass_cnt++;
        drive(1'b1, 16'd7, 1'b1, 3'd1);
        cycle();
        drive(1'b1, 16'd9, 1'b1, 3'd1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 16'd0, 1'b0, 3'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (out_valid !== 1'b0)
                $display("FAIL flush_drop_%0d got v=%b res=%0d exp v=0", i, out_valid, out_res); else pass_cnt++;
            cycle();
        end
    endtask

    task automatic test_zero_reg();
        out_ready = 1'b1;
        drive(1'b1, 16'h0033, 1'b1, 3'd0);
        cycle();
        total_cnt++;
        if (out_valid !== 1'b1 || out_wr_en !== 1'b0)
            $display("FAIL zero_suppress got v=%b wr=%b exp v=1 wr=0", out_valid, out_wr_en); else pass_cnt++;
        total_cnt++;
        if (z_out_valid !== 1'b1 || z_out_wr_en !== 1'b1)
            $display("FAIL zero_plain got v=%b wr=%b exp v=1 wr=1", z_out_valid, z_out_wr_en); else pass_cnt++;
        drive(1'b1, 16'h0044, 1'b1, 3'd5);
        cycle();
        total_cnt++;
        if (out_wr_en !== 1'b1 || z_out_wr_en !== 1'b1)
            $display("FAIL nonzero_wr got %b/%b exp 1/1", out_wr_en, z_out_wr_en); else pass_cnt++;
        drive(1'b1, 16'h0045, 1'b0, 3'd0);
        cycle();
        total_cnt++;
        if (out_wr_en !== 1'b0 || z_out_wr_en !== 1'b0)
            $display("FAIL no_wr got %b/%b exp 0/0", out_wr_en, z_out_wr_en); else pass_cnt++;
        drive(1'b0, 16'd0, 1'b0, 3'd0);
        cycle();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 16'd11, 1'b1, 3'd4);
        cycle();
        drive(1'b1, 16'd12, 1'b1, 3'd4);
        cycle();
        drive(1'b0, 16'd0, 1'b0, 3'd0);
        rst = 1'b0;
        #2;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_res !== 16'd0 || out_wr_en !== 1'b0)
            $display("FAIL async_reset got v=%b rdy=%b res=%0d wr=%b exp 0/1/0/0", out_valid, in_ready, out_res, out_wr_en);
        else pass_cnt++;
        mq.delete();
        exp_retire = 0;
        exp_stall = 0;
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        ent_t h;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 4) != 0, 16'($urandom), 1'($urandom), 3'($urandom));
            out_ready = (($urandom % 3) != 0);
            flush = (($urandom % 25) == 0);
            cycle();
            flush = 1'b0;
            total_cnt++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2))
                $display("FAIL rand_hs_%0d got v=%b rdy=%b exp v=%b rdy=%b", n, out_valid, in_ready, mq.size() > 0, mq.size() < 2);
            else pass_cnt++;
            if (mq.size() > 0) begin
                h = mq[0];
                total_cnt++;
                if (out_res !== h.res || out_inst !== h.inst || out_write_addr !== h.addr ||
                    out_wr_en !== (h.wr && h.addr != 3'd0) || z_out_wr_en !== h.wr)
                    $display("FAIL rand_data_%0d got res=%h inst=%h addr=%0d wr=%b/%b exp res=%h inst=%h addr=%0d wr=%b/%b",
                             n, out_res, out_inst, out_write_addr, out_wr_en, z_out_wr_en,
                             h.res, h.inst, h.addr, h.wr && h.addr != 3'd0, h.wr);
                else pass_cnt++;
            end
`ifdef MEM_WB_PIPE_PERF_EN
            total_cnt++;
            if (retire_cnt !== exp_retire || stall_cnt !== exp_stall)
                $display("FAIL rand_perf_%0d got %0d/%0d exp %0d/%0d", n, retire_cnt, stall_cnt, exp_retire, exp_stall);
            else pass_cnt++;
`endif
        end
        drive(1'b0, 16'd0, 1'b0, 3'd0);
        out_ready = 1'b1;
        repeat (3) cycle();
    endtask

`ifdef MEM_WB_PIPE_PERF_EN
    task automatic test_perf();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (retire_cnt !== 32'd0 || stall_cnt !== 32'd0)
            $display("FAIL perf_reset got %0d/%0d exp 0/0", retire_cnt, stall_cnt); else pass_cnt++;
        rst = 1'b1;
        mq.delete();
        cycle();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 16'(i), 1'b1, 3'(i));
            cycle();
        end
        drive(1'b0, 16'd0, 1'b0, 3'd0);
        out_ready = 1'b0;
        repeat (4) cycle();
        out_ready = 1'b1;
        cycle();
        total_cnt++;
        if (retire_cnt !== 32'd3 || stall_cnt !== 32'd4)
            $display("FAIL perf_count got %0d/%0d exp 3/4", retire_cnt, stall_cnt); else pass_cnt++;
        drive(1'b1, 16'd20, 1'b0, 3'd1);
        cycle();
        drive(1'b1, 16'd21, 1'b0, 3'd1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 16'd0, 1'b0, 3'd0);
        total_cnt++;
        if (retire_cnt !== 32'd3 || stall_cnt !== 32'd4 || out_valid !== 1'b0)
            $display("FAIL perf_flush got %0d/%0d v=%b exp 3/4 v=0", retire_cnt, stall_cnt, out_valid); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (retire_cnt !== 32'd0 || stall_cnt !== 32'd0)
            $display("FAIL perf_clear got %0d/%0d exp 0/0", retire_cnt, stall_cnt); else pass_cnt++;
        rst = 1'b1;
        mq.delete();
        exp_retire = 0;
        exp_stall = 0;
        cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_zero_reg();
        test_async_reset();
        test_random();
`ifdef MEM_WB_PIPE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
